regfile_wr_arbiter: RTL

Shares the single write port of the CPU register file between several write sources: ALU writeback, load return, link-register write, debug. Each cycle it picks one valid requester in round-robin order. The accepted write is registered for one cycle, then presented as a one-hot per-register write enable plus a shared data bus. These drive the `wrEn`/`wrData` inputs of the register-file's `register` instances directly. Writes to the zero register are accepted but suppressed.

---
 rtl/regfile_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/regfile_wr_arbiter.sv | 89 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write path.
package regfile_pkg;
    localparam int WIDTH    = 64;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int ZERO_REG = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts at ptr and wraps modulo N.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);
    always_comb begin
        int j;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        j   = 0;
        // Walk from the farthest position back to ptr so the closest valid requester wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (en && req[j]) begin
                idx = PW'(j);
                any = 1'b1;
            end
        end
        if (any) begin
            gnt[idx] = 1'b1;
        end
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin owner of the register-file write port: one registered write stage
// driving a one-hot write enable and a shared data bus.
module regfile_wr_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int WIDTH    = regfile_pkg::WIDTH,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG,
    parameter int SW       = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             hold,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ-1:0][WIDTH-1:0]    req_data,
    output logic [NUM_REQ-1:0]               req_ready,
    output logic [NUM_REGS-1:0]              wrEn,
    output logic [WIDTH-1:0]                 wrData,
    output logic [SW-1:0]                    wr_src,
    output logic                             wr_valid
);
    logic [SW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]  wr_data_q, wr_data_d;
    logic [SW-1:0]     wr_src_q, wr_src_d;

    logic [NUM_REQ-1:0] gnt;
    logic [SW-1:0]      gnt_idx;
    logic               gnt_any;

    // Reset gates the enable so no grant is visible while the block is held in reset.
    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (SW)
    ) u_arb (
        .req (req_valid),
        .ptr (rr_ptr_q),
        .en  (~hold & reset),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign req_ready = gnt;

    always_comb begin
        rr_ptr_d   = rr_ptr_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_src_d   = wr_src_q;
        if (gnt_any) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = req_addr[gnt_idx];
            wr_data_d  = req_data[gnt_idx];
            wr_src_d   = gnt_idx;
            rr_ptr_d   = (gnt_idx == SW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_q   <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_src_q   <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_src_q   <= wr_src_d;
        end
    end

    // The zero register never gets an enable, so suppressed writes still occupy the stage.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_dec
        localparam logic [ADDR_W-1:0] IDX     = ADDR_W'(gi);
        localparam bit                IS_ZERO = (gi == ZERO_REG);
        assign wrEn[gi] = wr_valid_q && (wr_addr_q == IDX) && !IS_ZERO;
    end

    assign wrData   = wr_data_q;
    assign wr_src   = wr_src_q;
    assign wr_valid = wr_valid_q;
endmodule
